// File: rtl/uart_rx_capture_buffer_pkg.sv
// Shared constants, width helpers and the stored-entry layout for the UART RX
// capture buffer and its per-channel FIFOs.
package uart_checker_pkg;

  localparam int C_NB_CHANNEL     = 2;
  localparam int C_DATA_WIDTH     = 8;
  localparam int C_ADDR_WIDTH     = 4;
  localparam int C_MAX_DATA_WIDTH = 9;

  function automatic int sel_width(input int nb_channel);
    return (nb_channel > 1) ? $clog2(nb_channel) : 1;
  endfunction

  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // Data is zero-extended to the widest legal character so one type fits all widths.
  typedef struct packed {
    logic                        perr;
    logic [C_MAX_DATA_WIDTH-1:0] data;
  } cap_entry_t;

endpackage

// File: rtl/uart_rx_capture_buffer_fifo.sv
// One channel of the capture buffer: rising-edge capture of the RX done level,
// circular storage, occupancy tracking and the sticky overflow flag.
module uart_cap_fifo
  import uart_checker_pkg::*;
#(
  parameter int G_DATA_WIDTH = C_DATA_WIDTH,
  parameter int G_ADDR_WIDTH = C_ADDR_WIDTH,
  localparam int CNT_W       = count_width(G_ADDR_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_rx_done,
  input  logic [G_DATA_WIDTH-1:0] i_rx_data,
  input  logic                    i_parity_err,
  input  logic                    i_flush,
  input  logic                    i_clr_err,
  input  logic                    i_rd_req,
  output logic                    o_rd_ok,
  output cap_entry_t              o_head,
  output logic [CNT_W-1:0]        o_count,
  output logic                    o_full,
  output logic                    o_empty,
  output logic                    o_overflow
);

  localparam int DEPTH = 2 ** G_ADDR_WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic                    rx_done_q;
  logic [G_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [G_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic                    cap, wr_ok, rd_ok, full, empty;
  cap_entry_t              wr_entry;
  cap_entry_t              mem_q [DEPTH];

  assign full  = (count_q == CNT_MAX);
  assign empty = (count_q == '0);

  always_comb begin
    cap           = i_rx_done & ~rx_done_q;
    rd_ok         = i_rd_req & ~empty & ~i_flush;
    // A read in the same cycle frees the slot the full-buffer capture needs.
    wr_ok         = cap & ~i_flush & (~full | rd_ok);
    wr_entry.perr = i_parity_err;
    wr_entry.data = C_MAX_DATA_WIDTH'(i_rx_data);
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = i_clr_err ? 1'b0 : overflow_q;
    if (cap & full & ~rd_ok & ~i_flush) begin
      overflow_d = 1'b1;
    end
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + G_ADDR_WIDTH'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + G_ADDR_WIDTH'(1);
      if (wr_ok & ~rd_ok) begin
        count_d = count_q + CNT_W'(1);
      end else if (rd_ok & ~wr_ok) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_done_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rx_done_q  <= i_rx_done;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign o_rd_ok    = rd_ok;
  assign o_head     = mem_q[rd_ptr_q];
  assign o_count    = count_q;
  assign o_full     = full;
  assign o_empty    = empty;
  assign o_overflow = overflow_q;

endmodule

// File: rtl/uart_rx_capture_buffer.sv
// Multi-channel UART RX capture buffer: per-channel FIFOs plus a shared read
// port that compares each read against an expected character.
module uart_rx_capture_buffer
  import uart_checker_pkg::*;
#(
  parameter int G_NB_CHANNEL = C_NB_CHANNEL,
  parameter int G_DATA_WIDTH = C_DATA_WIDTH,
  parameter int G_ADDR_WIDTH = C_ADDR_WIDTH,
  localparam int SEL_W       = sel_width(G_NB_CHANNEL),
  localparam int CNT_W       = count_width(G_ADDR_WIDTH)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [G_NB_CHANNEL-1:0]              i_rx_done,
  input  logic [G_NB_CHANNEL*G_DATA_WIDTH-1:0] i_rx_data,
  input  logic [G_NB_CHANNEL-1:0]              i_parity_err,
  input  logic [G_NB_CHANNEL-1:0]              i_flush,
  input  logic                                 i_clr_err,
  input  logic                                 i_rd_req,
  input  logic [SEL_W-1:0]                     i_rd_sel,
  input  logic                                 i_cmp_en,
  input  logic [G_DATA_WIDTH-1:0]              i_exp_data,
  output logic                                 o_rd_valid,
  output logic [G_DATA_WIDTH-1:0]              o_rd_data,
  output logic                                 o_rd_perr,
  output logic                                 o_rd_underflow,
  output logic [G_NB_CHANNEL*CNT_W-1:0]        o_count,
  output logic [G_NB_CHANNEL-1:0]              o_full,
  output logic [G_NB_CHANNEL-1:0]              o_empty,
  output logic [G_NB_CHANNEL-1:0]              o_overflow,
  output logic                                 o_mismatch,
  output logic [15:0]                          o_err_cnt
);

  logic [G_NB_CHANNEL-1:0] rd_req_ch;
  logic [G_NB_CHANNEL-1:0] rd_ok_ch;
  cap_entry_t              head_ch [G_NB_CHANNEL];

  for (genvar k = 0; k < G_NB_CHANNEL; k++) begin : g_ch
    assign rd_req_ch[k] = i_rd_req & (int'(i_rd_sel) == k);

    uart_cap_fifo #(
      .G_DATA_WIDTH (G_DATA_WIDTH),
      .G_ADDR_WIDTH (G_ADDR_WIDTH)
    ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_rx_done    (i_rx_done[k]),
      .i_rx_data    (i_rx_data[k*G_DATA_WIDTH +: G_DATA_WIDTH]),
      .i_parity_err (i_parity_err[k]),
      .i_flush      (i_flush[k]),
      .i_clr_err    (i_clr_err),
      .i_rd_req     (rd_req_ch[k]),
      .o_rd_ok      (rd_ok_ch[k]),
      .o_head       (head_ch[k]),
      .o_count      (o_count[k*CNT_W +: CNT_W]),
      .o_full       (o_full[k]),
      .o_empty      (o_empty[k]),
      .o_overflow   (o_overflow[k])
    );
  end

  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_underflow_q, rd_underflow_d;
  logic [G_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                    rd_perr_q, rd_perr_d;
  logic                    mismatch_q, mismatch_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
  logic [15:0]             err_base;
  logic                    any_rd_ok, mismatch_evt;
  cap_entry_t              sel_head;

  always_comb begin
    any_rd_ok = |rd_ok_ch;
    sel_head  = '0;
    for (int k = 0; k < G_NB_CHANNEL; k++) begin
      if (rd_ok_ch[k]) sel_head = head_ch[k];
    end
    mismatch_evt   = any_rd_ok & i_cmp_en &
                     ((sel_head.data != C_MAX_DATA_WIDTH'(i_exp_data)) | sel_head.perr);
    rd_valid_d     = any_rd_ok;
    rd_underflow_d = i_rd_req & ~any_rd_ok;
    rd_data_d      = any_rd_ok ? sel_head.data[G_DATA_WIDTH-1:0] : rd_data_q;
    rd_perr_d      = any_rd_ok ? sel_head.perr : rd_perr_q;
    // Clear and a new error in the same cycle leave exactly one error recorded.
    mismatch_d     = (i_clr_err ? 1'b0 : mismatch_q) | mismatch_evt;
    err_base       = i_clr_err ? 16'd0 : err_cnt_q;
    err_cnt_d      = err_base;
    if (mismatch_evt && (err_base != 16'hFFFF)) begin
      err_cnt_d = err_base + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q     <= 1'b0;
      rd_underflow_q <= 1'b0;
      rd_data_q      <= '0;
      rd_perr_q      <= 1'b0;
      mismatch_q     <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      rd_valid_q     <= rd_valid_d;
      rd_underflow_q <= rd_underflow_d;
      rd_data_q      <= rd_data_d;
      rd_perr_q      <= rd_perr_d;
      mismatch_q     <= mismatch_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign o_rd_valid     = rd_valid_q;
  assign o_rd_underflow = rd_underflow_q;
  assign o_rd_data      = rd_data_q;
  assign o_rd_perr      = rd_perr_q;
  assign o_mismatch     = mismatch_q;
  assign o_err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_capture_buffer.sv
// Directed bench for uart_rx_capture_buffer (2 channels, 8-bit data, depth 16)
// with hand-computed expectations checked by immediate assertions.
module tb_uart_rx_capture_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  i_rx_done;
  logic [15:0] i_rx_data;
  logic [1:0]  i_parity_err;
  logic [1:0]  i_flush;
  logic        i_clr_err;
  logic        i_rd_req;
  logic [0:0]  i_rd_sel;
  logic        i_cmp_en;
  logic [7:0]  i_exp_data;
  logic        o_rd_valid;
  logic [7:0]  o_rd_data;
  logic        o_rd_perr;
  logic        o_rd_underflow;
  logic [9:0]  o_count;
  logic [1:0]  o_full;
  logic [1:0]  o_empty;
  logic [1:0]  o_overflow;
  logic        o_mismatch;
  logic [15:0] o_err_cnt;

  int checks = 0;
  int errors = 0;

  uart_rx_capture_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_rx_done      (i_rx_done),
    .i_rx_data      (i_rx_data),
    .i_parity_err   (i_parity_err),
    .i_flush        (i_flush),
    .i_clr_err      (i_clr_err),
    .i_rd_req       (i_rd_req),
    .i_rd_sel       (i_rd_sel),
    .i_cmp_en       (i_cmp_en),
    .i_exp_data     (i_exp_data),
    .o_rd_valid     (o_rd_valid),
    .o_rd_data      (o_rd_data),
    .o_rd_perr      (o_rd_perr),
    .o_rd_underflow (o_rd_underflow),
    .o_count        (o_count),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_overflow     (o_overflow),
    .o_mismatch     (o_mismatch),
    .o_err_cnt      (o_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic capture(input int ch, input logic [7:0] d, input logic perr);
    i_rx_data[ch*8 +: 8] = d;
    i_parity_err[ch]     = perr;
    i_rx_done[ch]        = 1'b1;
    tick();
    i_rx_done[ch]        = 1'b0;
    i_parity_err[ch]     = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [0:0] sel);
    i_rd_req = 1'b1;
    i_rd_sel = sel;
    tick();
    i_rd_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_rx_done = '0; i_rx_data = '0; i_parity_err = '0; i_flush = '0;
    i_clr_err = 1'b0; i_rd_req = 1'b0; i_rd_sel = '0; i_cmp_en = 1'b0; i_exp_data = '0;
    tick(); tick();
    check("rst_empty", 32'(o_empty), 32'h3);
    check("rst_full", 32'(o_full), 32'h0);
    check("rst_count", 32'(o_count), 32'h0);
    check("rst_valid", 32'(o_rd_valid), 32'h0);
    check("rst_err_cnt", 32'(o_err_cnt), 32'h0);
    rst_n = 1'b1;
    tick();

    // Two characters on ch1, read back in order
    capture(1, 8'hA5, 1'b0);
    capture(1, 8'h3C, 1'b0);
    check("ch1_count2", 32'(o_count[9:5]), 32'd2);
    rd(1'b1);
    check("rd1_valid", 32'(o_rd_valid), 32'h1);
    check("rd1_data", 32'(o_rd_data), 32'hA5);
    check("rd1_count", 32'(o_count[9:5]), 32'd1);
    rd(1'b1);
    check("rd2_valid", 32'(o_rd_valid), 32'h1);
    check("rd2_data", 32'(o_rd_data), 32'h3C);
    check("rd2_count", 32'(o_count[9:5]), 32'd0);
    tick();
    check("valid_pulse", 32'(o_rd_valid), 32'h0);
    check("data_hold", 32'(o_rd_data), 32'h3C);
    check("ch1_empty", 32'(o_empty[1]), 32'h1);

    // Underflow on empty ch0
    rd(1'b0);
    check("uf_pulse", 32'(o_rd_underflow), 32'h1);
    check("uf_valid", 32'(o_rd_valid), 32'h0);
    check("uf_count", 32'(o_count[4:0]), 32'd0);
    tick();
    check("uf_single", 32'(o_rd_underflow), 32'h0);

    // 17 characters into ch0: 16 stored, last dropped
    for (int v = 1; v <= 17; v++) begin
      capture(0, 8'(v), 1'b0);
      if (v == 16) begin
        check("full_at16", 32'(o_full[0]), 32'h1);
        check("no_ovf_at16", 32'(o_overflow[0]), 32'h0);
      end
    end
    check("ovf_set", 32'(o_overflow[0]), 32'h1);
    check("ovf_count", 32'(o_count[4:0]), 32'd16);
    rd(1'b0);
    check("ovf_first", 32'(o_rd_data), 32'h01);
    check("ovf_cnt15", 32'(o_count[4:0]), 32'd15);

    // Refill, then capture and read in the same cycle while full
    capture(0, 8'h30, 1'b0);
    check("refull", 32'(o_full[0]), 32'h1);
    i_rx_data[7:0] = 8'h11;
    i_rx_done[0]   = 1'b1;
    i_rd_req       = 1'b1;
    i_rd_sel       = 1'b0;
    tick();
    i_rx_done[0]   = 1'b0;
    i_rd_req       = 1'b0;
    check("fullrw_data", 32'(o_rd_data), 32'h02);
    check("fullrw_count", 32'(o_count[4:0]), 32'd16);
    tick();
    for (int v = 3; v <= 16; v++) begin
      rd(1'b0);
      check("drain_data", 32'(o_rd_data), 32'(v));
    end
    rd(1'b0);
    check("drain_30", 32'(o_rd_data), 32'h30);
    rd(1'b0);
    check("drain_11", 32'(o_rd_data), 32'h11);
    check("drain_empty", 32'(o_count[4:0]), 32'd0);

    // Flush ch0 only; overflow flag survives
    capture(0, 8'h77, 1'b0);
    capture(1, 8'h66, 1'b0);
    check("pre_flush", 32'(o_count[4:0]), 32'd1);
    i_flush = 2'b01;
    tick();
    i_flush = 2'b00;
    check("flush_empty", 32'(o_empty[0]), 32'h1);
    check("flush_count", 32'(o_count[4:0]), 32'd0);
    check("flush_ovf", 32'(o_overflow[0]), 32'h1);
    check("flush_ch1", 32'(o_count[9:5]), 32'd1);
    capture(0, 8'h78, 1'b0);
    i_flush  = 2'b01;
    i_rd_req = 1'b1;
    i_rd_sel = 1'b0;
    tick();
    i_flush  = 2'b00;
    i_rd_req = 1'b0;
    check("flushrd_uf", 32'(o_rd_underflow), 32'h1);
    check("flushrd_valid", 32'(o_rd_valid), 32'h0);

    // Compare: match, then 0x55 vs 0x54, then clear
    capture(1, 8'h55, 1'b0);
    i_cmp_en   = 1'b1;
    i_exp_data = 8'h66;
    rd(1'b1);
    check("cmp_match", 32'(o_mismatch), 32'h0);
    i_exp_data = 8'h54;
    rd(1'b1);
    check("cmp_mm", 32'(o_mismatch), 32'h1);
    check("cmp_cnt", 32'(o_err_cnt), 32'd1);
    i_cmp_en   = 1'b0;
    i_clr_err  = 1'b1;
    tick();
    i_clr_err  = 1'b0;
    check("clr_mm", 32'(o_mismatch), 32'h0);
    check("clr_cnt", 32'(o_err_cnt), 32'd0);
    check("clr_ovf", 32'(o_overflow), 32'h0);

    // Stored parity error fails the compare even with matching data
    capture(1, 8'h12, 1'b1);
    i_cmp_en   = 1'b1;
    i_exp_data = 8'h12;
    rd(1'b1);
    check("perr_flag", 32'(o_rd_perr), 32'h1);
    check("perr_mm", 32'(o_mismatch), 32'h1);
    check("perr_cnt", 32'(o_err_cnt), 32'd1);

    // Clear coinciding with a new error leaves count 1
    capture(1, 8'h40, 1'b0);
    i_exp_data = 8'h41;
    i_clr_err  = 1'b1;
    rd(1'b1);
    i_clr_err  = 1'b0;
    i_cmp_en   = 1'b0;
    check("clrnew_cnt", 32'(o_err_cnt), 32'd1);
    check("clrnew_mm", 32'(o_mismatch), 32'h1);
    check("clrnew_perr", 32'(o_rd_perr), 32'h0);

    // Reset with ch1 loaded and a read in flight
    for (int v = 0; v < 5; v++) begin
      capture(1, 8'(8'h80 + v), 1'b0);
    end
    check("ch1_five", 32'(o_count[9:5]), 32'd5);
    i_rx_data[7:0] = 8'h9C;
    i_rx_done[0]   = 1'b1;
    i_rd_req       = 1'b1;
    i_rd_sel       = 1'b1;
    rst_n          = 1'b0;
    tick();
    i_rd_req       = 1'b0;
    check("mrst_valid", 32'(o_rd_valid), 32'h0);
    check("mrst_count", 32'(o_count), 32'h0);
    check("mrst_empty", 32'(o_empty), 32'h3);
    check("mrst_data", 32'(o_rd_data), 32'h0);
    check("mrst_mm", 32'(o_mismatch), 32'h0);
    check("mrst_cnt", 32'(o_err_cnt), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_cap", 32'(o_count[4:0]), 32'd1);
    i_rx_done[0] = 1'b0;
    rd(1'b0);
    check("post_rst_data", 32'(o_rd_data), 32'h9C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_capture_buffer.md
UART_RX_CAPTURE_BUFFER -- requirements
Module: uart_rx_capture_buffer

Interface
REQ-001 SHALL have parameter G_NB_CHANNEL, default 2, number of independent UART RX channels (1..16).
REQ-002 SHALL have parameter G_DATA_WIDTH, default 8, width of one received character (5..9).
REQ-003 SHALL have parameter G_ADDR_WIDTH, default 4, per-channel buffer depth 2**G_ADDR_WIDTH entries.
REQ-004 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports: i_rx_done  in  G_NB_CHANNEL  per-channel character-done level from the RX decoder.
REQ-006 SHALL have ports: i_rx_data  in  G_NB_CHANNEL*G_DATA_WIDTH  per-channel character, channel k at bits [k*W +: W].
REQ-007 SHALL have ports: i_parity_err  in  G_NB_CHANNEL  per-channel parity error, qualified by i_rx_done.
REQ-008 SHALL have ports: i_flush  in  G_NB_CHANNEL  per-channel buffer flush; i_clr_err  in  1  clear sticky flags and error counter.
REQ-009 SHALL have ports: i_rd_req  in  1  read strobe; i_rd_sel  in  SEL_W=max(1,clog2(N))  channel to read.
REQ-010 SHALL have ports: i_cmp_en  in  1  compare enable; i_exp_data  in  G_DATA_WIDTH  expected character for this read.
REQ-011 SHALL have ports: o_rd_valid  out  1; o_rd_data  out  G_DATA_WIDTH; o_rd_perr  out  1; o_rd_underflow  out  1.
REQ-012 SHALL have ports: o_count  out  G_NB_CHANNEL*(G_ADDR_WIDTH+1); o_full, o_empty, o_overflow  out  G_NB_CHANNEL each.
REQ-013 SHALL have ports: o_mismatch  out  1  sticky compare failure; o_err_cnt  out  16  compare failure count.

Function
REQ-014 SHALL register i_rx_done per channel and capture on rising edge only (done=1, previous=0); a held level captures once.
REQ-015 SHALL store each captured entry as {parity_err, data} at the write pointer, then increment write pointer and count.
REQ-016 SHALL wrap read/write pointers modulo 2**G_ADDR_WIDTH; count ranges 0..2**G_ADDR_WIDTH; full = count max, empty = count 0.
REQ-017 Capture while full with no same-cycle read on that channel: entry dropped, pointers unchanged, o_overflow[k] set (sticky).
REQ-018 Capture while full with same-cycle read on that channel: capture accepted, count unchanged.
REQ-019 Read accepted when i_rd_req=1 and channel i_rd_sel not empty: o_rd_valid=1, o_rd_data/o_rd_perr = head entry exactly one cycle later; read pointer increments.
REQ-020 Read on empty channel or i_rd_sel>=G_NB_CHANNEL: no pointer change, o_rd_valid=0, o_rd_underflow pulses 1 one cycle later.
REQ-021 Simultaneous capture and read on same non-full, non-empty channel: both performed, count unchanged; read on empty channel with same-cycle capture = underflow (no bypass).
REQ-022 o_rd_valid, o_rd_underflow SHALL be single-cycle pulses; o_rd_data/o_rd_perr hold last value otherwise.
REQ-023 i_flush[k] SHALL zero pointers and count of channel k next cycle, overriding same-cycle capture and read on k (read reports underflow); o_overflow[k] unaffected.
REQ-024 Accepted read with i_cmp_en=1: if data != i_exp_data or stored parity_err=1, set o_mismatch and increment o_err_cnt, saturating at 16'hFFFF.
REQ-025 i_clr_err SHALL clear o_overflow, o_mismatch, o_err_cnt next cycle; same-cycle new error wins (flag set, counter = 1).
REQ-026 o_full, o_empty, o_count SHALL be registered-state derived, reflecting updates one cycle after the causing event.

Reset
REQ-027 rst_n=0 SHALL, on the next clk edge, zero all pointers, counts, edge registers, o_rd_data, o_rd_perr, o_rd_valid, o_rd_underflow, o_overflow, o_mismatch, o_err_cnt; o_empty=all 1, o_full=all 0.
REQ-028 Buffer storage contents SHALL NOT require reset; reset mid-capture or mid-read discards in-flight operations.
REQ-029 After rst_n deassertion, an i_rx_done already high SHALL capture on the first active cycle (edge register reset to 0).

Structure
REQ-030 Shared package uart_checker_pkg SHALL hold default parameter constants, SEL_W/count-width functions, and the entry typedef.
REQ-031 Per-channel storage, pointers, count and full/empty SHALL be one sub-module uart_cap_fifo, generated G_NB_CHANNEL times; read mux, compare and error logic in the top.

Verification
REQ-032 N=2, depth 16: inject 0xA5 then 0x3C on ch1, read ch1 twice -> o_rd_data 0xA5 then 0x3C, one cycle after each req, o_count[1] 2->0.
REQ-033 Inject 17 characters on ch0 without reads -> o_full[0]=1 after 16th, 17th dropped, o_overflow[0]=1, first read returns character 1.
REQ-034 Read ch0 while empty -> o_rd_underflow single pulse, o_rd_valid=0, o_count[0] stays 0.
REQ-035 i_cmp_en=1, stored 0x55, i_exp_data 0x54 -> o_mismatch=1, o_err_cnt=1; then i_clr_err -> both 0.
REQ-036 ch0 full, same-cycle capture 0x11 and read -> count stays 16, 0x11 read last; i_flush[0] -> o_empty[0]=1 next cycle.
REQ-037 Assert rst_n=0 with ch1 holding 5 entries and read in flight -> all outputs at reset values, o_count[1]=0.
